frame_overlap_buffer: RTL and testbench

Front-end framing stage that sits directly upstream of the Hamming window in the MFCC feature pipeline. It accepts a continuous 16-bit audio sample stream and stores it in a circular buffer. It emits overlapping frames of FRAME_LEN samples, advancing HOP samples between frames. Output is a valid/ready stream with frame-boundary markers that the windowing stage consumes sample-by-sample.

---
 rtl/frame_overlap_buffer.sv | 91 +++++++++
 tb/tb_frame_overlap_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/frame_overlap_buffer.sv
// frame_overlap_buffer: circular sample buffer emitting overlapping FRAME_LEN frames every HOP samples
// Output side is a RAM read stage (ram_q) feeding a registered output, so a stall never costs a bubble.
module frame_overlap_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int BUF_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] frame_out,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_first,
    output logic              frame_last,
    output logic              overflow
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int IW = $clog2(FRAME_LEN) + 1;

    typedef enum logic [1:0] {IDLE, PREFETCH, EMIT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              q_valid;
    logic [AW:0]       wr_cnt, rd_base, avail;
    logic [IW-1:0]     rd_ptr, ld_cnt;
    logic [AW-1:0]     rd_addr;
    logic              wr_en, start, issue, q_move, xfer, frame_end;

    assign avail     = wr_cnt - rd_base;
    assign wr_en     = sample_valid && !rst && avail < (AW+1)'(BUF_DEPTH);
    assign xfer      = frame_valid && frame_ready;
    assign frame_end = xfer && frame_last;
    assign q_move    = q_valid && (!frame_valid || frame_ready);
    assign start     = state == IDLE && avail >= (AW+1)'(FRAME_LEN);
    // A read is issued only when ram_q will be free at the next edge
    assign issue     = start || (state != IDLE && rd_ptr < IW'(FRAME_LEN) && (!q_valid || q_move));
    assign rd_addr   = AW'(rd_base + (AW+1)'(rd_ptr));

    always_comb begin
        state_nx = state;
        state_nx = start ? PREFETCH : state == PREFETCH ? EMIT : frame_end ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= sample_in;
        if (issue) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_base     <= '0;
            rd_ptr      <= '0;
            ld_cnt      <= '0;
            q_valid     <= 1'b0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state    <= state_nx;
            overflow <= sample_valid && !wr_en;
            q_valid  <= issue || (q_valid && !q_move);
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (q_move) begin
                frame_out   <= ram_q;
                frame_valid <= 1'b1;
                frame_first <= ld_cnt == '0;
                frame_last  <= ld_cnt == IW'(FRAME_LEN - 1);
                ld_cnt      <= ld_cnt + 1'b1;
            end else if (xfer) begin
                frame_valid <= 1'b0;
                frame_first <= 1'b0;
                frame_last  <= 1'b0;
            end
            if (frame_end) begin
                rd_base <= rd_base + (AW+1)'(HOP);
                rd_ptr  <= '0;
                ld_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_overlap_buffer.sv
// tb_frame_overlap_buffer: random-ready stimulus checked against a queue-based frame model
module tb_frame_overlap_buffer;
    localparam int DW = 16, FL = 256, HOP = 128, BD = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] frame_out;
    logic          frame_valid, frame_ready = 1'b1, frame_first, frame_last, overflow;

    frame_overlap_buffer #(.DATA_W(DW), .FRAME_LEN(FL), .HOP(HOP), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_first(frame_first), .frame_last(frame_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rmode = 0;

    // accepted samples since the last reset; frame k sample i is acc[k*HOP+i]
    int acc[$];
    int frames_done, out_i, ovf_cnt, last_out, avail, idx, expv;
    logic ovf_exp = 1'b0, rst_seen = 1'b0, prev_stall = 1'b0, prev_adv = 1'b0;
    logic [DW-1:0] h_out;
    logic h_first, h_last;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_seen) chk("rst_valid", 32'(frame_valid), 0);
        if (rst) begin
            acc.delete();
            frames_done = 0; out_i = 0; ovf_cnt = 0; last_out = -1;
            ovf_exp = 0; prev_stall = 0; prev_adv = 0; rst_seen = 1;
        end else begin
            rst_seen = 0;
            chk("overflow", 32'(overflow), 32'(ovf_exp));
            if (overflow) ovf_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 32'(frame_valid), 1);
                chk("stall_data", 32'(frame_out), 32'(h_out));
                chk("stall_first", 32'(frame_first), 32'(h_first));
                chk("stall_last", 32'(frame_last), 32'(h_last));
            end
            if (prev_adv) chk("no_bubble", 32'(frame_valid), 1);
            avail = acc.size() - frames_done * HOP;
            prev_adv = 0;
            if (frame_valid && frame_ready) begin
                idx = frames_done * HOP + out_i;
                expv = idx < acc.size() ? acc[idx] : -1;
                chk("data", 32'(frame_out), expv);
                chk("first", 32'(frame_first), 32'(out_i == 0));
                chk("last", 32'(frame_last), 32'(out_i == FL - 1));
                last_out = int'(frame_out);
                prev_adv = out_i != FL - 1;
                out_i++;
                if (out_i == FL) begin
                    frames_done++;
                    out_i = 0;
                end
            end
            prev_stall = frame_valid && !frame_ready;
            h_out = frame_out; h_first = frame_first; h_last = frame_last;
            ovf_exp = 0;
            if (sample_valid) begin
                if (avail < BD) acc.push_back(int'(sample_in));
                else ovf_exp = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        frame_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 1) != 0) : 1'b0;
    endtask

    task automatic idle(int n);
        sample_valid = 0;
        repeat (n) tick();
    endtask

    task automatic feed(int first, int n, int gap);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1;
            sample_in = DW'(first + i);
            tick();
            sample_valid = 0;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1;
        sample_valid = 0;
        tick();
        tick();
        rst = 0;
        chk("reset_valid", 32'(frame_valid), 0);
        chk("reset_data", 32'(frame_out), 0);
        chk("reset_marks", 32'({frame_first, frame_last, overflow}), 0);
    endtask

    initial begin
        // in-order frame with one-cycle-per-sample transfer and exact start latency
        rmode = 0;
        do_reset();
        feed(0, FL, 1);
        tick();
        chk("latency_e1", 32'(frame_valid), 0);
        tick();
        chk("latency_e2", 32'(frame_valid), 1);
        chk("first_data", 32'(frame_out), 0);
        chk("first_mark", 32'(frame_first), 1);
        idle(300);
        chk("s1_frames", frames_done, 1);
        chk("s1_last", last_out, 255);
        // overlapping second frame
        feed(256, 128, 1);
        idle(300);
        chk("s2_frames", frames_done, 2);
        chk("s2_last", last_out, 383);
        chk("s2_ovf", ovf_cnt, 0);
        // random backpressure
        rmode = 1;
        do_reset();
        feed(0, FL, 1);
        idle(1500);
        chk("s3_frames", frames_done, 1);
        chk("s3_last", last_out, 255);
        // fill to capacity with the output blocked
        rmode = 2;
        do_reset();
        feed(0, 513, 1);
        idle(3);
        chk("s4_ovf", ovf_cnt, 1);
        chk("s4_kept", acc.size(), 512);
        rmode = 0;
        idle(1000);
        chk("s4_frames", frames_done, 3);
        chk("s4_last", last_out, 511);
        // reset part-way through a frame
        do_reset();
        feed(0, FL, 1);
        for (int i = 0; i < 2000 && out_i < 100; i++) tick();
        chk("s5_reach", 32'(out_i >= 100), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("s5_rst_valid", 32'(frame_valid), 0);
        feed(1000, FL, 1);
        idle(300);
        chk("s5_frames", frames_done, 1);
        chk("s5_last", last_out, 1255);
        // sparse input across several pointer wraps
        do_reset();
        feed(0, 1200, 4);
        idle(400);
        chk("s6_frames", frames_done, 8);
        chk("s6_last", last_out, 1151);
        chk("s6_ovf", ovf_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
